// File: rtl/fifo_write_arbiter_ctrl.sv
// Pointer, occupancy and flag controller for a 16-entry FIFO with an external RAM,
// plus a two-producer round-robin write arbiter and a sticky read-underrun flag.
module fifo_write_arbiter_ctrl #(
  parameter int SIZE     = 4,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 9,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             rd_req,
  input  logic             flush,
  output logic             gnt0,
  output logic             gnt1,
  output logic             we,
  output logic [WIDTH-1:0] wdata_out,
  output logic             re,
  output logic [SIZE-1:0]  w_pointer,
  output logic [SIZE-1:0]  r_pointer,
  output logic [SIZE:0]    count,
  output logic             full,
  output logic             empty,
  output logic             a_flag,
  output logic             ae_flag,
  output logic             rd_err
);

  localparam logic [SIZE:0] DEPTH  = (SIZE+1)'(1 << SIZE);
  localparam logic [SIZE:0] AF_LVL = (SIZE+1)'(AF_LEVEL);
  localparam logic [SIZE:0] AE_LVL = (SIZE+1)'(AE_LEVEL);

  logic [SIZE-1:0] w_ptr_q, w_ptr_d;
  logic [SIZE-1:0] r_ptr_q, r_ptr_d;
  logic [SIZE:0]   count_q, count_d;
  logic            last_gnt_q, last_gnt_d;
  logic            rd_err_q, rd_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q    <= '0;
      r_ptr_q    <= '0;
      count_q    <= '0;
      last_gnt_q <= 1'b1;
      rd_err_q   <= 1'b0;
    end else begin
      w_ptr_q    <= w_ptr_d;
      r_ptr_q    <= r_ptr_d;
      count_q    <= count_d;
      last_gnt_q <= last_gnt_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign full    = (count_q == DEPTH);
  assign empty   = (count_q == '0);
  assign a_flag  = (count_q > AF_LVL);
  assign ae_flag = (count_q < AE_LVL);

  // Under contention the producer not served last wins; last_gnt_q=1 favours req0.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!flush && !full) begin
      if (req0 && req1) begin
        if (last_gnt_q) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign we        = gnt0 | gnt1;
  assign wdata_out = gnt1 ? wdata1 : wdata0;
  assign re        = rd_req & ~empty & ~flush;

  always_comb begin
    w_ptr_d    = w_ptr_q;
    r_ptr_d    = r_ptr_q;
    count_d    = count_q;
    last_gnt_d = last_gnt_q;
    rd_err_d   = rd_err_q;
    if (flush) begin
      w_ptr_d    = '0;
      r_ptr_d    = '0;
      count_d    = '0;
      last_gnt_d = 1'b1;
      rd_err_d   = 1'b0;
    end else begin
      w_ptr_d = w_ptr_q + SIZE'(we);
      r_ptr_d = r_ptr_q + SIZE'(re);
      count_d = count_q + (SIZE+1)'(we) - (SIZE+1)'(re);
      if (we) last_gnt_d = gnt1;
      if (rd_req && empty) rd_err_d = 1'b1;
    end
  end

  assign w_pointer = w_ptr_q;
  assign r_pointer = r_ptr_q;
  assign count     = count_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_fifo_write_arbiter_ctrl.sv
// Directed bench for fifo_write_arbiter_ctrl: fill, arbitration, full/empty edges,
// pointer wrap, underrun error, flush and asynchronous reset.
module tb_fifo_write_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, rd_req, flush;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, we, re;
  logic [7:0] wdata_out;
  logic [3:0] w_pointer, r_pointer;
  logic [4:0] count;
  logic       full, empty, a_flag, ae_flag, rd_err;

  int n_chk  = 0;
  int n_pass = 0;

  fifo_write_arbiter_ctrl #(.SIZE(4), .WIDTH(8), .AF_LEVEL(9), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wdata0(wdata0), .wdata1(wdata1),
    .rd_req(rd_req), .flush(flush),
    .gnt0(gnt0), .gnt1(gnt1), .we(we), .wdata_out(wdata_out), .re(re),
    .w_pointer(w_pointer), .r_pointer(r_pointer), .count(count),
    .full(full), .empty(empty), .a_flag(a_flag), .ae_flag(ae_flag),
    .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    edge_step();
    flush = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    rst_n = 1'b0;
    idle();
    wdata0 = 8'h00;
    wdata1 = 8'h00;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", ae_flag, 1);
    chk("rst_full", full, 0);
    chk("rst_af", a_flag, 0);
    chk("rst_rderr", rd_err, 0);
    chk("rst_wptr", w_pointer, 0);
    chk("rst_rptr", r_pointer, 0);
    chk("rst_we_re", {we, re, gnt0, gnt1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_step();

    // Fill with producer 0 for 17 cycles
    exp_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      req0 = 1'b1;
      wdata0 = 8'(8'h40 + i);
      #1;
      if (i < 16) begin
        chk("fill_gnt0", gnt0, 1);
        chk("fill_wdata", wdata_out, 8'(8'h40 + i));
        chk("fill_wptr", w_pointer, i);
      end else begin
        chk("fill_full", full, 1);
        chk("fill_gnt0_blocked", {gnt0, we}, 0);
      end
      edge_step();
      if (exp_cnt < 16) exp_cnt++;
      chk("fill_count", count, exp_cnt);
      chk("fill_af", a_flag, (exp_cnt > 9) ? 1 : 0);
      chk("fill_ae", ae_flag, (exp_cnt < 2) ? 1 : 0);
    end

    // At full: read wins, no write
    rd_req = 1'b1;
    #1;
    chk("full_re", re, 1);
    chk("full_gnt0", gnt0, 0);
    edge_step();
    chk("full_rd_count", count, 15);
    chk("full_rd_rptr", r_pointer, 1);
    #1;
    chk("both_gnt0", gnt0, 1);
    chk("both_re", re, 1);
    edge_step();
    chk("both_count", count, 15);
    chk("both_wptr", w_pointer, 1);
    chk("both_rptr", r_pointer, 2);

    // flush beats pending requests
    flush = 1'b1;
    #1;
    chk("flush_gnt", {gnt0, gnt1, re}, 0);
    edge_step();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_ptrs", {w_pointer, r_pointer}, 0);
    idle();

    // Round-robin under continuous contention
    req0 = 1'b1; req1 = 1'b1; wdata0 = 8'hA0; wdata1 = 8'hB1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_gnt", {gnt0, gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_wdata", wdata_out, (k % 2 == 0) ? 8'hA0 : 8'hB1);
      edge_step();
    end
    chk("rr_count", count, 6);
    do_flush();

    // Pointer wrap: 20 writes interleaved with 20 reads
    for (int k = 0; k < 20; k++) begin
      req0 = 1'b1; rd_req = 1'b0;
      #1;
      chk("wrap_re_empty", re, 0);
      edge_step();
      req0 = 1'b0; rd_req = 1'b1;
      #1;
      chk("wrap_re", re, 1);
      edge_step();
    end
    idle();
    chk("wrap_wptr", w_pointer, 4);
    chk("wrap_rptr", r_pointer, 4);
    chk("wrap_count", count, 0);
    chk("wrap_empty", empty, 1);
    chk("wrap_rderr", rd_err, 0);

    // Underrun sets sticky error
    rd_req = 1'b1;
    #1;
    chk("under_re", re, 0);
    edge_step();
    chk("under_err", rd_err, 1);
    rd_req = 1'b0; req1 = 1'b1;
    edge_step();
    req1 = 1'b0; rd_req = 1'b1;
    edge_step();
    rd_req = 1'b0;
    chk("under_sticky", rd_err, 1);
    chk("under_ptrs", {w_pointer, r_pointer}, 8'h55);
    do_flush();
    chk("under_flush_err", rd_err, 0);
    chk("under_flush_ptrs", {w_pointer, r_pointer}, 0);

    // Asynchronous reset mid-fill
    req0 = 1'b1;
    for (int k = 0; k < 7; k++) edge_step();
    req0 = 1'b0;
    chk("mid_count", count, 7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_wptr", w_pointer, 0);
    chk("async_empty", empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("post_rst_gnt", {gnt0, gnt1}, 2'b10);
    idle();
    edge_step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter_ctrl.md
# fifo_write_arbiter_ctrl

Pointer and flag controller for the team's 16-entry FIFO, with a round-robin write arbiter for two producers. It grants one producer per cycle and steers that producer's data and the write pointer to the external dual-port RAM. It advances the read pointer for one consumer and keeps the occupancy count. It raises full, empty, almost-full and almost-empty flags, plus a sticky read-underrun error. The storage RAM is external; this block only sequences it.

## Interface
Parameters:
- SIZE, 4, pointer width; FIFO depth = 2^SIZE (16)
- WIDTH, 8, data word width
- AF_LEVEL, 9, a_flag asserted when count > AF_LEVEL
- AE_LEVEL, 2, ae_flag asserted when count < AE_LEVEL

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0, req1  input  1 each  producer write requests, held until granted
- wdata0, wdata1  input  WIDTH each  producer data
- rd_req  input  1  consumer read request
- flush  input  1  synchronous clear, highest priority
- gnt0, gnt1  output  1 each  write grant, one-hot or zero
- we  output  1  RAM write enable (gnt0 | gnt1)
- wdata_out  output  WIDTH  granted producer's data (wdata1 if gnt1, else wdata0)
- re  output  1  RAM read enable / read accepted
- w_pointer, r_pointer  output  SIZE  RAM write/read addresses
- count  output  SIZE+1  occupancy, 0..2^SIZE
- full, empty, a_flag, ae_flag  output  1 each  status flags
- rd_err  output  1  sticky underrun error

## Operation
- State registers: w_pointer, r_pointer, count, last_gnt (1 = producer 1 served last), rd_err.
- Status flags are combinational decodes of registered count:
  - full = (count == 2^SIZE)
  - empty = (count == 0)
  - a_flag = (count > AF_LEVEL)
  - ae_flag = (count < AE_LEVEL)
- Grant logic is combinational. When flush=1 or full=1, both grants are 0. Otherwise:
  - Only req0 → gnt0.
  - Only req1 → gnt1.
  - Both → grant the producer not served last (gnt0 if last_gnt=1, gnt1 if last_gnt=0).
- last_gnt updates on every edge where we=1, to the index granted. Otherwise it holds.
- re = rd_req & ~empty & ~flush.
- The write and read decisions use the current count. At full with rd_req, the read proceeds and no write is granted that cycle. At empty with a request, the write proceeds and re=0.
- Clock-edge updates, evaluated in this order:
  - flush: pointers and count go to 0, rd_err clears, last_gnt goes to 1.
  - Otherwise: w_pointer += we, r_pointer += re, count += we − re.
  - Pointers are SIZE bits and wrap naturally (15 → 0). count never exceeds 2^SIZE and never goes below 0, by construction.
- rd_err sets on any edge with rd_req & empty & ~flush. It stays set until flush or reset.
- Arithmetic: count is SIZE+1 bits unsigned. Threshold compares are unsigned against the parameter values.

## Timing
- Reset (rst_n low, asynchronous):
  - w_pointer, r_pointer and count = 0.
  - last_gnt = 1.
  - rd_err = 0.
  - Resulting outputs: empty=1, ae_flag=1, full=0, a_flag=0, gnt*/we/re=0 (while requests are idle).
- Reset mid-operation clears all state immediately. Stored RAM contents are abandoned.
- Grant latency: 0 cycles. A producer sees gntN in the same cycle as reqN, and its word is written at that edge. It may drop or renew reqN in the next cycle.
- A losing producer waits at most one cycle under continuous contention.
- count and the flags reflect a write or read one edge after the accepting cycle.
- Read data appears from the external RAM per that RAM's latency. re and r_pointer are valid in the accepting cycle.
- Simultaneous write and read (not full, not empty): count is unchanged and both pointers advance.
- flush with requests present: no grant and no re that cycle. Requests are served from the next cycle.

## Test plan
- Reset, then idle → count=0, empty=1, ae_flag=1, full=0, a_flag=0, rd_err=0, w_pointer=r_pointer=0.
- req0 held for 17 cycles, no reads:
  - gnt0 for 16 cycles, then full=1, gnt0=0 on cycle 17, count=16.
  - a_flag rises after the 10th write (count=10).
  - ae_flag falls after the 2nd write.
- req0 and req1 both held from reset, 6 cycles → grants gnt0,gnt1,gnt0,gnt1,gnt0,gnt1; wdata_out alternates wdata0/wdata1; count=6.
- At full (count=16), rd_req and req0 asserted for 1 cycle → re=1, gnt0=0, count=15, r_pointer=1. Next cycle with both asserted → gnt0=1, re=1, count stays 15.
- Wrap-around: 20 single writes interleaved with 20 reads → w_pointer=r_pointer=4, count=0, empty=1, no rd_err.
- rd_req while empty → re=0, rd_err=1 next cycle and held through later valid traffic. flush → rd_err=0, pointers 0. rst_n pulsed low mid-fill (count=7) → all state 0 immediately, without waiting for a clock edge.
